// File: rtl/pcie_ep_pkg.sv
// Shared definitions for the PCIe endpoint burst model: FSM states,
// completion status codes, config-space offsets and request-header bit positions.
package pcie_ep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_CPL_HDR,
    ST_CPL_DATA
  } state_e;

  localparam logic [7:0] CPL_SC = 8'h00;
  localparam logic [7:0] CPL_UR = 8'h01;

  localparam logic [7:0] CFG_ID   = 8'h00;
  localparam logic [7:0] CFG_CMD  = 8'h04;
  localparam logic [7:0] CFG_ERR  = 8'h08;
  localparam logic [7:0] CFG_BAR0 = 8'h10;

  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_LEN_MSB = 15;
  localparam int HDR_WR_BIT  = 16;
  localparam int HDR_CFG_BIT = 24;

endpackage

// File: rtl/pcie_ep_cfg_space.sv
// Config register file for the PCIe endpoint: ID (RO), command (RW),
// optional UR error counter, BAR0 (RW, low address bits hardwired to 0).
// Optional feature macro: PCIE_EP_ERR_CNT_EN (error counter at 0x08).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   we_i         write strobe, applied at the next clock edge
//   addr_i       dword-aligned byte offset
//   wdata_i      write data
//   err_inc_i    one-cycle pulse per UR completion sent
//   rdata_o      combinational read data for addr_i
//   mem_en_o     command[1], memory-space enable
module pcie_ep_cfg_space
  import pcie_ep_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [15:0] VENDOR_ID = 16'h1234,
  parameter logic [15:0] DEVICE_ID = 16'h5678
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        err_inc_i,
  output logic [31:0] rdata_o,
  output logic        mem_en_o
);

  // BAR0 decodes the whole memory window, so bits below its size read 0.
  localparam int          BAR_LO   = $clog2(MEM_DEPTH) + 2;
  localparam logic [31:0] BAR_MASK = ~((32'h1 << BAR_LO) - 32'h1);

  logic [15:0] cmd_q;
  logic [31:0] bar_q;
  logic [31:0] err_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      bar_q <= '0;
    end else if (we_i) begin
      if (addr_i == CFG_CMD)  cmd_q <= wdata_i[15:0];
      if (addr_i == CFG_BAR0) bar_q <= wdata_i & BAR_MASK;
    end
  end

`ifdef PCIE_EP_ERR_CNT_EN
  logic [15:0] err_q;

  // Clear wins; increments and config writes never coincide anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (we_i && addr_i == CFG_ERR) begin
      err_q <= '0;
    end else if (err_inc_i && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_rd = {16'h0, err_q};
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc_i;
  assign err_rd = '0;
`endif

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CFG_ID:   rdata_o = {DEVICE_ID, VENDOR_ID};
      CFG_CMD:  rdata_o = {16'h0, cmd_q};
      CFG_ERR:  rdata_o = err_rd;
      CFG_BAR0: rdata_o = bar_q;
      default:  rdata_o = '0;
    endcase
  end

  assign mem_en_o = cmd_q[1];

endmodule

// File: rtl/pcie_ep_burst.sv
// PCIe endpoint transaction-layer model with burst memory reads/writes.
// Decodes simplified request TLPs (header, address, optional payload),
// serves a config space and a BAR0 memory, returns completions with status.
// Optional feature macro: PCIE_EP_ERR_CNT_EN (UR error counter in config 0x08).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rx_data/valid/ready request word stream
//   tx_data/valid/ready completion word stream, tx_last marks final word
//   busy                high whenever the FSM is not idle
//
// state       | meaning
// ST_IDLE     | waiting for request header
// ST_ADDR     | waiting for address word; request validity decided here
// ST_WDATA    | consuming write payload (written, or discarded if UR)
// ST_CPL_HDR  | presenting completion header
// ST_CPL_DATA | streaming read data
module pcie_ep_burst
  import pcie_ep_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter int          MAX_LEN   = 16,
  parameter logic [15:0] VENDOR_ID = 16'h1234,
  parameter logic [15:0] DEVICE_ID = 16'h5678
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy
);

  localparam int IW = $clog2(MEM_DEPTH);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic          wr_q, wr_d;
  logic          cfg_q, cfg_d;
  logic          ur_q, ur_d;
  logic [5:0]    off_q, off_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    rem_q, rem_d;

  logic [31:0]   mem [MEM_DEPTH];

  logic          mem_we;
  logic          cfg_we;
  logic          err_inc;
  logic [31:0]   cfg_rdata;
  logic          mem_en;
  logic [32:0]   req_end;
  logic          req_ur;
  logic          rd_sc;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^rx_data[1:0];

  pcie_ep_cfg_space #(
    .MEM_DEPTH (MEM_DEPTH),
    .VENDOR_ID (VENDOR_ID),
    .DEVICE_ID (DEVICE_ID)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (cfg_we),
    .addr_i    ({off_q, 2'b00}),
    .wdata_i   (rx_data),
    .err_inc_i (err_inc),
    .rdata_o   (cfg_rdata),
    .mem_en_o  (mem_en)
  );

  // 33-bit end index so a near-4GiB address cannot wrap into range.
  assign req_end = {3'b000, rx_data[31:2]} + {25'h0, len_q};

  assign req_ur = (len_q == 8'd0)
               || (len_q > 8'(MAX_LEN))
               || ( cfg_q && len_q != 8'd1)
               || (!cfg_q && !mem_en)
               || (!cfg_q && req_end > 33'(MEM_DEPTH));

  assign rd_sc = !wr_q && !ur_q;
  assign busy  = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wr_q    <= 1'b0;
      cfg_q   <= 1'b0;
      ur_q    <= 1'b0;
      off_q   <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      cfg_q   <= cfg_d;
      ur_q    <= ur_d;
      off_q   <= off_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // Memory is intentionally not reset; a burst cut by reset keeps its words.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= rx_data;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_d     = wr_q;
    cfg_d    = cfg_q;
    ur_d     = ur_q;
    off_d    = off_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    mem_we   = 1'b0;
    cfg_we   = 1'b0;
    err_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_d   = rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
          wr_d    = rx_data[HDR_WR_BIT];
          cfg_d   = rx_data[HDR_CFG_BIT];
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          ur_d    = req_ur;
          off_d   = rx_data[7:2];
          ptr_d   = rx_data[IW+1:2];
          rem_d   = len_q;
          state_d = (wr_q && len_q != 8'd0) ? ST_WDATA : ST_CPL_HDR;
        end
      end

      ST_WDATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          // UR payload is still counted off, just never stored.
          if (!ur_q) begin
            if (cfg_q) cfg_we = 1'b1;
            else       mem_we = 1'b1;
          end
          ptr_d = ptr_q + IW'(1);
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = ST_CPL_HDR;
        end
      end

      ST_CPL_HDR: begin
        tx_valid = 1'b1;
        tx_data  = {15'h0, wr_q, (rd_sc ? len_q : 8'h00), (ur_q ? CPL_UR : CPL_SC)};
        tx_last  = !rd_sc;
        if (tx_ready) begin
          err_inc = ur_q;
          state_d = rd_sc ? ST_CPL_DATA : ST_IDLE;
        end
      end

      ST_CPL_DATA: begin
        tx_valid = 1'b1;
        tx_data  = cfg_q ? cfg_rdata : mem[ptr_q];
        tx_last  = (rem_q == 8'd1);
        if (tx_ready) begin
          ptr_d = ptr_q + IW'(1);
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_ep_burst.sv
module tb_pcie_ep_burst;

  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;

  pcie_ep_burst #(
    .MEM_DEPTH (256),
    .MAX_LEN   (MAX_LEN),
    .VENDOR_ID (16'h1234),
    .DEVICE_ID (16'h5678)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit tmo = 1'b0;
  int stall_bad = 0;

  // {last, data}
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  logic [31:0] mdl_mem [256];
  logic [15:0] mdl_cmd = '0;
  logic [31:0] mdl_bar = '0;
  logic [15:0] mdl_err = '0;

  function automatic logic [31:0] mk_hdr(input bit cfg, input bit wr, input logic [7:0] len);
    return {7'h0, cfg, 7'h0, wr, len, 8'h00};
  endfunction

  function automatic logic [31:0] mdl_cfg_rd(input logic [7:0] off);
    case ({off[7:2], 2'b00})
      8'h00:   return 32'h5678_1234;
      8'h04:   return {16'h0, mdl_cmd};
      8'h08:   return {16'h0, mdl_err};
      8'h10:   return mdl_bar;
      default: return 32'h0;
    endcase
  endfunction

  task automatic mdl_cfg_wr(input logic [7:0] off, input logic [31:0] w);
    case ({off[7:2], 2'b00})
      8'h04: mdl_cmd = w[15:0];
`ifdef PCIE_EP_ERR_CNT_EN
      8'h08: mdl_err = 16'h0;
`endif
      8'h10: mdl_bar = w & 32'hFFFF_FC00;
      default: ;
    endcase
  endtask

  task automatic model_req(input bit cfg, input bit wr, input logic [7:0] len,
                           input logic [31:0] addr, input logic [31:0] pl[$]);
    bit          ur;
    logic [31:0] widx;
    logic [32:0] endw;
    bit          sc_rd;
    widx = addr >> 2;
    endw = {1'b0, widx} + {25'h0, len};
    ur = (len == 8'd0) || (int'(len) > MAX_LEN) || (cfg && len != 8'd1)
      || (!cfg && !mdl_cmd[1]) || (!cfg && endw > 33'd256);
    sc_rd = !wr && !ur;
    if (wr && !ur) begin
      if (cfg) mdl_cfg_wr(addr[7:0], pl[0]);
      else for (int i = 0; i < int'(len); i++) mdl_mem[int'(widx) + i] = pl[i];
    end
    exp_q.push_back({!sc_rd, 15'h0, wr, (sc_rd ? len : 8'h00), (ur ? 8'h01 : 8'h00)});
    if (sc_rd) begin
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back({(i == int'(len) - 1), cfg ? mdl_cfg_rd(addr[7:0]) : mdl_mem[int'(widx) + i]});
    end
`ifdef PCIE_EP_ERR_CNT_EN
    if (ur && mdl_err != 16'hFFFF) mdl_err = mdl_err + 16'd1;
`endif
  endtask

  task automatic rx_word(input logic [31:0] w, input bit gaps);
    int b;
    if (gaps && $urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_data  = w;
    rx_valid = 1'b1;
    b = 0;
    while (!rx_ready && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 200) tmo = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic [31:0] hdr, input logic [31:0] addr,
                          input logic [31:0] pl[$], input bit gaps);
    rx_word(hdr, gaps);
    rx_word(addr, gaps);
    foreach (pl[i]) rx_word(pl[i], gaps);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic collect(input bit bp);
    int          b;
    bit          done;
    bit          hv;
    logic [32:0] held;
    done = 1'b0; hv = 1'b0; b = 0; held = '0;
    while (!done && b < 400) begin
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid) begin
        if (hv && {tx_last, tx_data} !== held) stall_bad++;
        if (tx_ready) begin
          got_q.push_back({tx_last, tx_data});
          hv = 1'b0;
          if (tx_last) done = 1'b1;
        end else begin
          held = {tx_last, tx_data};
          hv   = 1'b1;
        end
      end
      @(posedge clk); #1;
      b++;
    end
    tx_ready = 1'b0;
    if (!done) tmo = 1'b1;
  endtask

  task automatic run_raw(input bit cfg, input bit wr, input logic [7:0] len, input logic [31:0] addr,
                         input logic [31:0] pl[$], input bit gaps, input bit bp);
    send_req(mk_hdr(cfg, wr, len), addr, pl, gaps);
    collect(bp);
  endtask

  task automatic run_req(input bit cfg, input bit wr, input logic [7:0] len, input logic [31:0] addr,
                         input logic [31:0] pl[$], input bit gaps, input bit bp);
    model_req(cfg, wr, len, addr, pl);
    run_raw(cfg, wr, len, addr, pl, gaps, bp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_cmd = '0; mdl_bar = '0; mdl_err = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last: got %b want 0", tx_last); end
    checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_cfg_read();
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    exp_q.push_back(33'h0_0000_0100);
    exp_q.push_back(33'h1_5678_1234);
    send_req(mk_hdr(1'b1, 1'b0, 8'd1), 32'h0, nopl, 1'b0);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL cpl_latency: tx_valid %b want 1", tx_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_cpl: got %b want 1", busy); end
    collect(1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL cfg_read: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL cfg_read: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL cfg_read_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL cfg_read_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_cfg_regs();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    pl = {32'hFFFF_FFFF};
    run_req(1'b1, 1'b1, 8'd1, 32'h10, pl, 1'b0, 1'b0);
    exp_q.push_back(33'h0_0000_0100);
    exp_q.push_back(33'h1_FFFF_FC00);
    run_raw(1'b1, 1'b0, 8'd1, 32'h10, nopl, 1'b0, 1'b0);
    pl = {32'h0};
    run_req(1'b1, 1'b1, 8'd1, 32'h00, pl, 1'b0, 1'b0);
    exp_q.push_back(33'h0_0000_0100);
    exp_q.push_back(33'h1_5678_1234);
    run_raw(1'b1, 1'b0, 8'd1, 32'h00, nopl, 1'b0, 1'b0);
    run_req(1'b1, 1'b0, 8'd1, 32'h0C, nopl, 1'b0, 1'b0);
    run_req(1'b1, 1'b0, 8'd2, 32'h04, nopl, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL cfg_regs: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL cfg_regs: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL cfg_regs_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL cfg_regs_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_mem_burst();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    int c0;
    pl = {32'h0000_0002};
    run_req(1'b1, 1'b1, 8'd1, 32'h04, pl, 1'b0, 1'b0);
    run_req(1'b1, 1'b0, 8'd1, 32'h04, nopl, 1'b0, 1'b0);
    pl = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    model_req(1'b0, 1'b1, 8'd4, 32'h20, pl);
    c0 = cyc;
    send_req(mk_hdr(1'b0, 1'b1, 8'd4), 32'h20, pl, 1'b0);
    checks++; if (cyc - c0 !== 6) begin errors++; $display("FAIL write_burst_cycles: got %0d want 6", cyc - c0); end
    collect(1'b0);
    model_req(1'b0, 1'b0, 8'd4, 32'h20, nopl);
    send_req(mk_hdr(1'b0, 1'b0, 8'd4), 32'h20, nopl, 1'b0);
    c0 = cyc;
    collect(1'b0);
    checks++; if (cyc - c0 !== 5) begin errors++; $display("FAIL read_stream_cycles: got %0d want 5", cyc - c0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL mem_burst: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL mem_burst: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mem_burst_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL mem_burst_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_ur_disabled();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    pl = {32'h1357_9BDF};
    run_req(1'b0, 1'b1, 8'd1, 32'h40, pl, 1'b0, 1'b0);
    pl = {32'h0};
    run_req(1'b1, 1'b1, 8'd1, 32'h04, pl, 1'b0, 1'b0);
    exp_q.push_back(33'h1_0000_0001);
    run_raw(1'b0, 1'b0, 8'd1, 32'h40, nopl, 1'b0, 1'b0);
    pl = {32'hDEAD_BEEF};
    run_req(1'b0, 1'b1, 8'd1, 32'h40, pl, 1'b0, 1'b0);
    pl = {32'h2};
    run_req(1'b1, 1'b1, 8'd1, 32'h04, pl, 1'b0, 1'b0);
    exp_q.push_back(33'h0_0000_0100);
    exp_q.push_back(33'h1_1357_9BDF);
    run_raw(1'b0, 1'b0, 8'd1, 32'h40, nopl, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL ur_disabled: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL ur_disabled: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ur_disabled_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL ur_disabled_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_range();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    pl = {32'hCAFE_0FFC};
    run_req(1'b0, 1'b1, 8'd1, 32'h3FC, pl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'd2, 32'h3FC, nopl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'd1, 32'h3FC, nopl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'd0, 32'h100, nopl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'(MAX_LEN + 1), 32'h0, nopl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'd2, 32'hFFFF_FFFC, nopl, 1'b0, 1'b0);
    run_req(1'b0, 1'b1, 8'd0, 32'h100, nopl, 1'b0, 1'b0);
    pl = {};
    for (int i = 0; i <= MAX_LEN; i++) pl.push_back(32'hBAD0_0000 + 32'(i));
    run_req(1'b0, 1'b1, 8'(MAX_LEN + 1), 32'h0, pl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'd1, 32'h3FC, nopl, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL range: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL range: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL range_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL range_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back($urandom());
    run_req(1'b0, 1'b1, 8'd8, 32'h80, pl, 1'b1, 1'b0);
    stall_bad = 0;
    run_req(1'b0, 1'b0, 8'd8, 32'h80, nopl, 1'b0, 1'b1);
    run_req(1'b0, 1'b0, 8'd8, 32'h80, nopl, 1'b1, 1'b1);
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled want 0", stall_bad); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL backpressure: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL backpressure: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL backpressure_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL backpressure_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    rx_word(mk_hdr(1'b0, 1'b1, 8'd4), 1'b0);
    rx_word(32'hC0, 1'b0);
    rx_word(32'h1111_0000, 1'b0);
    rx_word(32'h2222_0001, 1'b0);
    rx_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_wdata: got %b want 1", busy); end
    mdl_mem[8'h30] = 32'h1111_0000;
    mdl_mem[8'h31] = 32'h2222_0001;
    rst_n = 1'b0;
    #1;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_rx_ready: got %b want 1", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL midrst_tx_data: got %h want 0", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    do_reset();
    run_req(1'b1, 1'b0, 8'd1, 32'h04, nopl, 1'b0, 1'b0);
    pl = {32'h2};
    run_req(1'b1, 1'b1, 8'd1, 32'h04, pl, 1'b0, 1'b0);
    run_req(1'b0, 1'b0, 8'd2, 32'hC0, nopl, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL reset_mid: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL reset_mid: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL reset_mid_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL reset_mid_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  task automatic test_err_cnt();
    logic [31:0] pl[$];
    logic [31:0] nopl[$];
    logic [32:0] e, g;
    run_req(1'b1, 1'b0, 8'd1, 32'h08, nopl, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_req(1'b0, 1'b0, 8'd0, 32'h0, nopl, 1'b0, 1'b0);
    run_req(1'b1, 1'b0, 8'd1, 32'h08, nopl, 1'b0, 1'b0);
    pl = {32'h1234_5678};
    run_req(1'b1, 1'b1, 8'd1, 32'h08, pl, 1'b0, 1'b0);
    run_req(1'b1, 1'b0, 8'd1, 32'h08, nopl, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL err_cnt: missing word, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin errors++; $display("FAIL err_cnt: got %h want %h", g, e); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL err_cnt_extra: %0d extra words want 0", got_q.size()); end
    got_q.delete();
    checks++; if (tmo) begin errors++; $display("FAIL err_cnt_timeout: timed out want handshake"); end
    tmo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_read();
    test_cfg_regs();
    test_mem_burst();
    test_ur_disabled();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_err_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
